// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if
//   Bundles the two requester command/ack sets, the memory port and the
//   status outputs of the round-robin memory arbiter.
//   Ports of the interface: none (signals only).
//   Signals:
//     req_x/we_x/addr_x/wdata_x  requester -> arbiter command (x = a, b)
//     ack_x/rdata_x              arbiter -> requester completion and read data
//     mem_we/mem_addr/mem_wdata  arbiter -> memory port
//     mem_rdata                  memory -> arbiter read data
//     busy                       arbiter is not idle
//     dbg_state                  current arbiter FSM state (debug observation)
//   Modports:
//     slave  - the arbiter side
//     master - the requesters plus memory side (testbench / system)
//
// Handshake: a requester raises req_x with a stable command and holds it
// high until it sees ack_x (a single-cycle pulse). The command is captured
// only at the grant edge; later changes of we/addr/wdata are ignored. A req
// still high in the IDLE cycle after the ack is treated as a new command.
interface mem_rr_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              ack_a;
  logic [DATA_W-1:0] rdata_a;

  logic              req_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              ack_b;
  logic [DATA_W-1:0] rdata_b;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic [1:0]        dbg_state;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    output ack_a, rdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    output ack_b, rdata_b,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, dbg_state
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    input  ack_a, rdata_a,
    output req_b, we_b, addr_b, wdata_b,
    input  ack_b, rdata_b,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, dbg_state
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
//   Two-requester round-robin arbiter and sequencer for a single-port
//   synchronous memory (write on mem_we=1 at an edge, otherwise the addressed
//   word is registered onto mem_rdata and valid the next cycle).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    mem_rr_arbiter_if.slave: requester A/B command and ack sets,
//            memory port, busy and dbg_state
//   Sequence per access: IDLE (grant edge) -> ISSUE -> COMPLETE -> IDLE.
//   ack arrives two cycles after the grant edge; one access per three cycles.
module mem_rr_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_rr_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  // prio/owner encoding: 0 = requester A, 1 = requester B
  state_t            state_q,     state_d;
  logic              prio_q,      prio_d;
  logic              owner_q,     owner_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              grant_b;

  // B wins when it is the only requester, or both request and prio names B.
  assign grant_b = bus.req_b & (~bus.req_a | prio_q);

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          owner_d     = grant_b;
          prio_d      = ~grant_b;
          mem_we_d    = grant_b ? bus.we_b    : bus.we_a;
          mem_addr_d  = grant_b ? bus.addr_b  : bus.addr_a;
          mem_wdata_d = grant_b ? bus.wdata_b : bus.wdata_a;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // The memory samples at the end of ISSUE; the address stays put so
        // the read result lines up with the COMPLETE cycle and later cycles
        // only perform harmless reads of the same word.
        mem_we_d = 1'b0;
        state_d  = COMPLETE;
      end
      COMPLETE: begin
        state_d = IDLE;
      end
      default: begin
        mem_we_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // Asynchronous reset so mem_we (and the ack/busy decode) drop the moment
  // rst_n falls, abandoning any in-flight write before it reaches an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // ack is a pure decode of state and owner, so it lasts exactly the one
  // COMPLETE cycle. Read data passes straight through from the memory; on a
  // write it shows whatever the memory held, which callers ignore.
  assign bus.ack_a   = (state_q == COMPLETE) && (owner_q == 1'b0);
  assign bus.ack_b   = (state_q == COMPLETE) && (owner_q == 1'b1);
  assign bus.rdata_a = bus.mem_rdata;
  assign bus.rdata_b = bus.mem_rdata;

  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter
//   Directed testbench for mem_rr_arbiter with a behavioural 16x8 single-port
//   synchronous memory attached to the memory port.
module tb_mem_rr_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [DATA_W-1:0] mem [16];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h30 + 8'(i);
    bus.mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    else            bus.mem_rdata     <= mem[bus.mem_addr];
  end

  // ---------------- driver tasks ----------------
  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic idle_inputs();
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;
  endtask

  // Issue one command from side (0=A, 1=B) and wait up to 10 cycles for its
  // ack. lat is the number of edges from request to ack, or -1 on timeout.
  task automatic run_cmd(input bit side, input bit we, input logic [3:0] addr,
                         input logic [7:0] wd, output logic [7:0] rd,
                         output int lat);
    lat = -1;
    rd  = 'x;
    if (side == 1'b0) begin
      bus.req_a = 1'b1; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wd;
    end else begin
      bus.req_b = 1'b1; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wd;
    end
    for (int i = 1; i <= 10; i++) begin
      step();
      if (side == 1'b0 && bus.ack_a === 1'b1) begin
        rd = bus.rdata_a; lat = i; break;
      end
      if (side == 1'b1 && bus.ack_b === 1'b1) begin
        rd = bus.rdata_b; lat = i; break;
      end
    end
    if (side == 1'b0) bus.req_a = 1'b0;
    else              bus.req_b = 1'b0;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_addr !== 4'h0 || bus.mem_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_mem_port: got we=%b addr=%h wdata=%h, want 0/0/00",
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (bus.ack_a !== 1'b0 || bus.ack_b !== 1'b0 || bus.busy !== 1'b0 ||
        bus.dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_status: got ack_a=%b ack_b=%b busy=%b state=%0d, want 0/0/0/0",
               bus.ack_a, bus.ack_b, bus.busy, bus.dbg_state);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    logic [7:0] rd;
    int lat;
    // A writes 0xA5 @3, checked cycle by cycle.
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 4'd3; bus.wdata_a = 8'hA5;
    step(); // grant edge passed -> ISSUE
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 4'd3 || bus.mem_wdata !== 8'hA5 ||
        bus.ack_a !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_issue: got we=%b addr=%0d wdata=%h ack_a=%b busy=%b, want 1/3/a5/0/1",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.ack_a, bus.busy);
    end
    // Changing the command now must have no effect.
    bus.wdata_a = 8'h00; bus.addr_a = 4'd9;
    step(); // COMPLETE
    checks++;
    if (bus.ack_a !== 1'b1 || bus.ack_b !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack: got ack_a=%b ack_b=%b mem_we=%b, want 1/0/0",
               bus.ack_a, bus.ack_b, bus.mem_we);
    end
    bus.req_a = 1'b0;
    step(); // IDLE
    checks++;
    if (bus.ack_a !== 1'b0 || bus.busy !== 1'b0 || mem[3] !== 8'hA5) begin
      errors++;
      $display("FAIL wr_done: got ack_a=%b busy=%b mem3=%h, want 0/0/a5",
               bus.ack_a, bus.busy, mem[3]);
    end
    run_cmd(1'b0, 1'b0, 4'd3, 8'h00, rd, lat);
    checks++;
    if (rd !== 8'hA5 || lat !== 2) begin
      errors++;
      $display("FAIL rd_after_wr: got rdata=%h lat=%0d, want a5 lat=2", rd, lat);
    end
  endtask

  task automatic test_both_req();
    logic [7:0] rd;
    int lat;
    int t_a;
    int t_b;
    apply_reset();
    t_a = -1; t_b = -1;
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 4'd15;
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 4'd15; bus.wdata_b = 8'h5A;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (bus.ack_a === 1'b1 && t_a < 0) begin
        t_a = c;
        checks++;
        if (bus.rdata_a !== 8'h3F || bus.ack_b !== 1'b0) begin
          errors++;
          $display("FAIL both_a_read: got rdata_a=%h ack_b=%b, want 3f/0",
                   bus.rdata_a, bus.ack_b);
        end
        bus.req_a = 1'b0;
      end
      if (bus.ack_b === 1'b1 && t_b < 0) begin
        t_b = c;
        bus.req_b = 1'b0;
      end
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    checks++;
    if (t_a !== 2 || t_b !== 5) begin
      errors++;
      $display("FAIL both_order: got ack_a@%0d ack_b@%0d, want 2 and 5", t_a, t_b);
    end
    run_cmd(1'b0, 1'b0, 4'd15, 8'h00, rd, lat);
    checks++;
    if (rd !== 8'h5A || lat !== 2) begin
      errors++;
      $display("FAIL both_readback: got rdata=%h lat=%0d, want 5a lat=2", rd, lat);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int last_t;
    bit side;
    logic [7:0] exp_rd;
    logic [7:0] got_rd;
    apply_reset();
    n = 0; last_t = -1;
    // A keeps reading @3 (0xA5), B keeps reading @4 (never written, 0x34).
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 4'd3;
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 4'd4;
    for (int c = 1; c <= 40 && n < 6; c++) begin
      step();
      if (bus.ack_a === 1'b1 || bus.ack_b === 1'b1) begin
        side   = bus.ack_b;
        got_rd = side ? bus.rdata_b : bus.rdata_a;
        exp_rd = (n % 2 == 0) ? 8'hA5 : 8'h34;
        checks++;
        if (side !== 1'(n % 2) || (bus.ack_a & bus.ack_b) !== 1'b0 || got_rd !== exp_rd ||
            (n > 0 && c - last_t !== 3) || (n == 0 && c !== 2)) begin
          errors++;
          $display("FAIL b2b_ack%0d: got side=%0d rdata=%h gap=%0d, want side=%0d rdata=%h gap=3",
                   n, side, got_rd, c - last_t, n % 2, exp_rd);
        end
        last_t = c;
        n++;
      end
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d acks, want 6", n);
    end
    step();
    step();
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    int lat;
    bit saw_ack;
    saw_ack = 1'b0;
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 4'd7; bus.wdata_b = 8'h77;
    step(); // ISSUE of the B write
    checks++;
    if (bus.mem_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue: got mem_we=%b, want 1", bus.mem_we);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || bus.ack_a !== 1'b0 || bus.ack_b !== 1'b0 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_now: got we=%b ack_a=%b ack_b=%b busy=%b, want 0/0/0/0",
               bus.mem_we, bus.ack_a, bus.ack_b, bus.busy);
    end
    bus.req_b = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (bus.ack_b === 1'b1) saw_ack = 1'b1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (bus.ack_b === 1'b1) saw_ack = 1'b1;
    end
    checks++;
    if (saw_ack !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_ack: got ack_b seen=%b, want 0", saw_ack);
    end
    // B-only request after release is granted; @7 still holds its old value.
    run_cmd(1'b1, 1'b0, 4'd7, 8'h00, rd, lat);
    checks++;
    if (rd !== 8'h37 || lat !== 2) begin
      errors++;
      $display("FAIL mid_readback: got rdata=%h lat=%0d, want 37 lat=2", rd, lat);
    end
  endtask

  task automatic test_addr_bounds();
    logic [7:0] rd;
    int lat;
    run_cmd(1'b0, 1'b1, 4'd0, 8'h11, rd, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL bound_wr0: got lat=%0d, want 2", lat);
    end
    run_cmd(1'b1, 1'b1, 4'd15, 8'hEE, rd, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL bound_wr15: got lat=%0d, want 2", lat);
    end
    run_cmd(1'b1, 1'b0, 4'd0, 8'h00, rd, lat);
    checks++;
    if (rd !== 8'h11 || lat !== 2) begin
      errors++;
      $display("FAIL bound_rd0: got rdata=%h lat=%0d, want 11 lat=2", rd, lat);
    end
    run_cmd(1'b0, 1'b0, 4'd15, 8'h00, rd, lat);
    checks++;
    if (rd !== 8'hEE || lat !== 2) begin
      errors++;
      $display("FAIL bound_rd15: got rdata=%h lat=%0d, want ee lat=2", rd, lat);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_both_req();
    test_back_to_back();
    test_reset_mid();
    test_addr_bounds();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
